// File: rtl/cpu_pipe_pkg.sv
// Shared types for the CPU pipeline registers: decoded control bundle, ID->EXE payload,
// skid-buffer occupancy states and a small stall-event helper.
package cpu_pipe_pkg;

    localparam int ALUC_W     = 4;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              aluimm;
        logic [ALUC_W-1:0] aluc;
    } idexe_ctrl_t;

    typedef struct packed {
        idexe_ctrl_t           ctrl;
        logic [REG_ADDR_W-1:0] dest_reg;
        logic [DATA_W-1:0]     qa;
        logic [DATA_W-1:0]     qb;
        logic [DATA_W-1:0]     imm32;
    } idexe_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // A held instruction that EXE refuses, unless it is being killed this cycle.
    function automatic logic stall_event(input logic valid, input logic ready, input logic kill);
        return valid && !ready && !kill;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer with a registered in_ready, so there is no combinational
// path from out_ready to in_ready. flush empties it from any state.
//
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0
//   ST_ONE   | main entry valid, skid slot free
//   ST_TWO   | main and skid entries valid, in_ready=0
module pipe_skid_buf
    import cpu_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_ready_q;
    logic         in_fire;

    assign in_fire   = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= ST_EMPTY;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_ready) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q     <= in_data;
                        state      <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (out_ready) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the promotion can happen
                    if (out_ready) begin
                        main_q     <= skid_q;
                        state      <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/idexe_stage_reg.sv
// ID->EXE pipeline register with valid/ready handshake, flush, bubble forcing and a
// saturating stall counter. Define IDEXE_SKID_EN for the two-entry registered-ready variant.
module idexe_stage_reg
    import cpu_pipe_pkg::stall_event;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int ALUC_W      = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   wreg,
    input  logic                   m2reg,
    input  logic                   wmem,
    input  logic                   aluimm,
    input  logic [ALUC_W-1:0]      aluc,
    input  logic [REG_ADDR_W-1:0]  dest_reg,
    input  logic [DATA_W-1:0]      qa,
    input  logic [DATA_W-1:0]      qb,
    input  logic [DATA_W-1:0]      imm32,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   ewreg,
    output logic                   em2reg,
    output logic                   ewmem,
    output logic                   ealuimm,
    output logic [ALUC_W-1:0]      ealuc,
    output logic [REG_ADDR_W-1:0]  edest_reg,
    output logic [DATA_W-1:0]      eqa,
    output logic [DATA_W-1:0]      eqb,
    output logic [DATA_W-1:0]      eimm32,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PAY_W = 4 + ALUC_W + REG_ADDR_W + 3 * DATA_W;

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] held;
    logic             h_wreg;
    logic             h_wmem;

    assign in_pay = {wreg, m2reg, wmem, aluimm, aluc, dest_reg, qa, qb, imm32};

`ifdef IDEXE_SKID_EN
    pipe_skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_pay),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (held)
    );
`else
    logic valid_q;

    assign out_valid = valid_q;
    assign in_ready  = !valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            held    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            held    <= in_pay;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end
`endif

    assign {h_wreg, em2reg, h_wmem, ealuimm, ealuc, edest_reg, eqa, eqb, eimm32} = held;

    // A bubble must never write the register file or memory.
    assign ewreg = out_valid && h_wreg;
    assign ewmem = out_valid && h_wmem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_event(out_valid, out_ready, flush) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_idexe_stage_reg.sv
// Randomized and directed bench for idexe_stage_reg against a queue-based transaction model.
module tb_idexe_stage_reg;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        aluimm;
        logic [3:0]  aluc;
        logic [4:0]  dest_reg;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] imm32;
    } entry_t;

`ifdef IDEXE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   flush = 1'b0;
    logic   in_valid = 1'b0;
    logic   out_ready = 1'b0;
    entry_t cur = '0;

    logic        in_ready, out_valid;
    logic        ewreg, em2reg, ewmem, ealuimm;
    logic [3:0]  ealuc;
    logic [4:0]  edest_reg;
    logic [31:0] eqa, eqb, eimm32;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic        s_ewreg, s_em2reg, s_ewmem, s_ealuimm;
    logic [3:0]  s_ealuc;
    logic [4:0]  s_edest_reg;
    logic [31:0] s_eqa, s_eqb, s_eimm32;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    idexe_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .wreg(cur.wreg), .m2reg(cur.m2reg), .wmem(cur.wmem), .aluimm(cur.aluimm),
        .aluc(cur.aluc), .dest_reg(cur.dest_reg), .qa(cur.qa), .qb(cur.qb), .imm32(cur.imm32),
        .out_valid(out_valid), .out_ready(out_ready),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm), .ealuc(ealuc),
        .edest_reg(edest_reg), .eqa(eqa), .eqb(eqb), .eimm32(eimm32), .stall_cnt(stall_cnt)
    );

    idexe_stage_reg #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .wreg(cur.wreg), .m2reg(cur.m2reg), .wmem(cur.wmem), .aluimm(cur.aluimm),
        .aluc(cur.aluc), .dest_reg(cur.dest_reg), .qa(cur.qa), .qb(cur.qb), .imm32(cur.imm32),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .ewreg(s_ewreg), .em2reg(s_em2reg), .ewmem(s_ewmem), .ealuimm(s_ealuimm), .ealuc(s_ealuc),
        .edest_reg(s_edest_reg), .eqa(s_eqa), .eqb(s_eqb), .eimm32(s_eimm32),
        .stall_cnt(s_stall_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO of accepted instructions, last-shown entry, two counters.
    entry_t q[$];
    entry_t shown = '0;
    int     m_cnt16 = 0;
    int     m_cnt4 = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t rand_entry();
        entry_t e;
        e = {$urandom, $urandom, $urandom, $urandom};
        return e;
    endfunction

    function automatic logic model_in_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic model_reset();
        q.delete();
        shown   = '0;
        m_cnt16 = 0;
        m_cnt4  = 0;
    endtask

    task automatic check_outputs();
        entry_t exp;
        exp = shown;
        if (q.size() == 0) begin
            exp.wreg = 1'b0;
            exp.wmem = 1'b0;
        end
        chk("out_valid", out_valid, q.size() > 0);
        chk("ebus", {ewreg, em2reg, ewmem, ealuimm, ealuc, edest_reg, eqa, eqb, eimm32}, exp);
        chk("stall_cnt", stall_cnt, m_cnt16);
        chk("stall_cnt_w4", s_stall_cnt, m_cnt4);
        chk("out_valid_w4", s_out_valid, q.size() > 0);
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic ir, in_fire, out_fire;
        #1;
        ir = model_in_ready();
        chk("in_ready", in_ready, ir);
        in_fire  = in_valid && ir;
        out_fire = (q.size() > 0) && out_ready;
        @(posedge clk);
        if ((q.size() > 0) && !out_ready && !flush) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(cur);
        end
        if (q.size() > 0) shown = q[0];
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check_outputs();

        // 1: asynchronous reset while an entry is held
        cur = rand_entry();
        cur.wreg = 1'b1;
        cur.qa = 32'hA5A5_0001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_reset_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ewreg", ewreg, 1'b0);
        chk("rst_eqa", eqa, 32'h0);
        chk("rst_stall_cnt", stall_cnt, 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // 2: streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cur = rand_entry();
            cur.qa = 32'h11 * i;
            step();
            chk("stream_eqa", eqa, 32'h11 * i);
        end
        in_valid = 1'b0;
        step();
        chk("stream_stall_cnt", stall_cnt, 16'h0);

        // 3: stall with a second and third instruction waiting
        do_reset();
        cur = rand_entry();
        cur.qb = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            cur = rand_entry();
            cur.qb = 32'h1000 + i;
            step();
        end
        chk("stall_eqb", eqb, 32'hDEAD_BEEF);
        chk("stall_cnt5", stall_cnt, 16'd5);
        #1 chk("stall_in_ready", in_ready, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // 4: flush kills the held entry and the incoming one
        do_reset();
        cur = rand_entry();
        cur.wreg = 1'b1;
        cur.wmem = 1'b1;
        in_valid = 1'b1;
        step();
        cur = rand_entry();
        cur.wreg = 1'b1;
        cur.dest_reg = 5'd7;
        flush = 1'b1;
        step();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_ewreg", ewreg, 1'b0);
        chk("flush_ewmem", ewmem, 1'b0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("flush_no_ghost", out_valid, 1'b0);
        end

        // 5: counter saturation on the 4-bit instance
        do_reset();
        cur = rand_entry();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt4", s_stall_cnt, 4'd15);
        chk("sat_cnt16", stall_cnt, 16'd20);
        step();
        chk("sat_hold", s_stall_cnt, 4'd15);

`ifdef IDEXE_SKID_EN
        // 6: skid ordering
        do_reset();
        in_valid = 1'b1;
        cur = rand_entry();
        cur.qa = 32'h1;
        step();
        cur = rand_entry();
        cur.qa = 32'h2;
        step();
        in_valid = 1'b0;
        chk("skid_eqa_a", eqa, 32'h1);
        out_ready = 1'b1;
        step();
        chk("skid_eqa_b", eqa, 32'h2);
        step();
        step();
        chk("skid_empty", out_valid, 1'b0);
        #1 chk("skid_in_ready", in_ready, 1'b1);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cur       = rand_entry();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
